// File: rtl/openddr_cfg_apb_arb_if.sv
// openddr_cfg_apb_arb_if
//  Bundles the requester command/response channels and the APB master bus of
//  the configuration-port arbiter.
//  Modports:
//   master - arbiter view: drives req_ready, rsp_*, busy and the APB controls,
//            observes requester commands and the APB slave response.
//   slave  - environment view (requesters plus APB slave), the mirror image.
//  Signals:
//   req_valid/req_ready/req_wr  NUM_REQ bits, one per requester
//   req_addr/req_wdata          flattened, requester i at [i*W +: W]
//   rsp_valid                   NUM_REQ bits, one-cycle pulse to the owner
//   rsp_rdata/rsp_err           shared response payload
//   busy                        transfer in flight
//   psel/penable/pwr/paddr/pwdata/prdata/pready/pslverr  APB bus
interface openddr_cfg_apb_arb_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      busy;
    logic                      psel;
    logic                      penable;
    logic                      pwr;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic [DATA_W-1:0]         prdata;
    logic                      pready;
    logic                      pslverr;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               psel, penable, pwr, paddr, pwdata
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               psel, penable, pwr, paddr, pwdata
    );
endinterface

// File: rtl/openddr_cfg_apb_arb.sv
// openddr_cfg_apb_arb
//  Round-robin arbiter plus APB master sharing the memory controller's single
//  APB configuration port between NUM_REQ requesters. One command is accepted
//  at a time and run as a SETUP/ACCESS transfer; the result is returned to the
//  owning requester as a one-cycle rsp_valid pulse.
//  Ports:
//   clk  - clock, all logic on posedge
//   rst  - asynchronous active-high reset
//   bus  - openddr_cfg_apb_arb_if.master (requester channels + APB bus)
//  Optional feature:
//   OPENDDR_CFG_ARB_TIMEOUT_EN - abort an ACCESS phase that sees no pready
//   within TIMEOUT_CYCLES cycles; the owner gets rsp_err=1, rsp_rdata=0.
module openddr_cfg_apb_arb #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                   clk,
    input logic                   rst,
    openddr_cfg_apb_arb_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand;
    logic               grant_found;
    logic               accept;
    logic               complete;
    logic [ID_W-1:0]    id_q;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

`ifdef OPENDDR_CFG_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
    logic            abort;
`endif

    // Scan requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
`ifdef OPENDDR_CFG_ARB_TIMEOUT_EN
        abort      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (grant_found) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                // pready in the terminal timeout cycle still counts as completion
                if (bus.pready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
`ifdef OPENDDR_CFG_ARB_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Grant is visible combinationally in IDLE, and forced low while in reset.
    always_comb begin
        bus.req_ready = '0;
        if (state == IDLE && grant_found && !rst) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    assign bus.psel    = (state != IDLE);
    assign bus.penable = (state == ACCESS);
    assign bus.busy    = (state != IDLE);
    assign bus.pwr     = wr_q;
    assign bus.paddr   = addr_q;
    assign bus.pwdata  = wdata_q;

    // State, command latch and response register. APB address/data hold
    // their last values while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id_q          <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            state         <= state_next;
            bus.rsp_valid <= '0;
            if (accept) begin
                id_q    <= grant_id;
                wr_q    <= bus.req_wr[grant_id];
                addr_q  <= bus.req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
                wdata_q <= bus.req_wdata[int'(grant_id)*DATA_W +: DATA_W];
                rr_ptr  <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (complete) begin
                bus.rsp_valid[id_q] <= 1'b1;
                bus.rsp_rdata       <= wr_q ? '0 : bus.prdata;
                bus.rsp_err         <= bus.pslverr;
            end
`ifdef OPENDDR_CFG_ARB_TIMEOUT_EN
            if (abort) begin
                bus.rsp_valid[id_q] <= 1'b1;
                bus.rsp_rdata       <= '0;
                bus.rsp_err         <= 1'b1;
            end
`endif
        end
    end

`ifdef OPENDDR_CFG_ARB_TIMEOUT_EN
    // Counts ACCESS cycles from 0; cleared whenever not in ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state != ACCESS) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_openddr_cfg_apb_arb.sv
// tb_openddr_cfg_apb_arb
//  Self-checking bench for openddr_cfg_apb_arb. Requesters and an APB memory
//  slave live in the bench; a transaction-level reference model predicts the
//  grant, the APB phase timing and the response of every command.
//  Define OPENDDR_CFG_ARB_TIMEOUT_EN to include the timeout scenario.
module tb_openddr_cfg_apb_arb;
    localparam int NUM_REQ        = 3;
    localparam int ADDR_W         = 10;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    openddr_cfg_apb_arb_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    openddr_cfg_apb_arb #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] s_mem   [256];

    bit                pend    [NUM_REQ];
    logic              c_wr    [NUM_REQ];
    logic [ADDR_W-1:0] c_addr  [NUM_REQ];
    logic [DATA_W-1:0] c_wdata [NUM_REQ];

    int gen_prob  = 0;
    int force_w   = 0;
    int force_err = 0;
    int w_max     = 4;
    bit stall     = 1'b0;

    // Reference model: one outstanding transaction, described by its accept
    // cycle, its wait-state count and its expected response.
    bit                m_active = 1'b0;
    int                m_ptr    = 0;
    int                m_T      = 0;
    int                m_id     = 0;
    int                tx_wait  = 0;
    logic              m_wr     = 1'b0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [DATA_W-1:0] m_wdata  = '0;
    logic [DATA_W-1:0] m_rdata  = '0;
    logic              m_err    = 1'b0;

    int                s_cnt      = 0;
    int                acc_cycles = 0;
    int                grant_log[$];
    logic [DATA_W-1:0] last_rdata = '0;
    logic              last_err   = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic driveInputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]                      = pend[i];
            bus.req_wr[i]                         = c_wr[i];
            bus.req_addr[i*ADDR_W +: ADDR_W]      = c_addr[i];
            bus.req_wdata[i*DATA_W +: DATA_W]     = c_wdata[i];
        end
    endtask

    function automatic bit anyPend();
        bit r = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) r |= pend[i];
        return r;
    endfunction

    task automatic issue(input int id, input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
        pend[id]    = 1'b1;
        c_wr[id]    = wr;
        c_addr[id]  = addr;
        c_wdata[id] = wdata;
    endtask

    // One clock cycle: check outputs against the model, play the APB slave,
    // refresh requester inputs, then check and record the grant.
    task automatic applyStimulus();
        logic [NUM_REQ-1:0] exp_ready;
        logic [NUM_REQ-1:0] exp_rsp;
        logic               exp_psel;
        logic               exp_pen;
        int                 g;
        int                 idx;

        @(negedge clk);
        cyc++;

        exp_psel = m_active && cyc >= m_T + 1 && cyc <= m_T + 2 + tx_wait;
        exp_pen  = m_active && cyc >= m_T + 2 && cyc <= m_T + 2 + tx_wait;
        exp_rsp  = '0;
        if (m_active && cyc == m_T + 3 + tx_wait) exp_rsp[m_id] = 1'b1;

        checkOutput("psel", 32'(bus.psel), 32'(exp_psel));
        checkOutput("penable", 32'(bus.penable), 32'(exp_pen));
        checkOutput("busy", 32'(bus.busy), 32'(exp_psel));
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
        if (exp_psel) begin
            checkOutput("paddr", 32'(bus.paddr), 32'(m_addr));
            checkOutput("pwr", 32'(bus.pwr), 32'(m_wr));
            if (m_wr) checkOutput("pwdata", bus.pwdata, m_wdata);
        end
        if (bus.psel && bus.penable) acc_cycles++;
        if (bus.rsp_valid != '0) begin
            last_rdata = bus.rsp_rdata;
            last_err   = bus.rsp_err;
        end
        if (exp_rsp != '0) begin
            checkOutput("rsp_rdata", bus.rsp_rdata, m_rdata);
            checkOutput("rsp_err", 32'(bus.rsp_err), 32'(m_err));
            m_active = 1'b0;
        end

        // APB memory slave with a programmed number of wait states
        bus.pready  = 1'b0;
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom_range(0, 1));
        if (bus.psel && !bus.penable) begin
            s_cnt = 0;
        end else if (bus.psel && bus.penable) begin
            if (!stall && s_cnt == tx_wait) begin
                bus.pready  = 1'b1;
                bus.prdata  = s_mem[bus.paddr[9:2]];
                bus.pslverr = m_err;
                if (bus.pwr) s_mem[bus.paddr[9:2]] = bus.pwdata;
            end else begin
                s_cnt++;
            end
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i]) begin
                c_wr[i]    = 1'($urandom_range(0, 1));
                c_addr[i]  = {8'($urandom_range(0, 255)), 2'b00};
                c_wdata[i] = $urandom;
                if ($urandom_range(0, 99) < gen_prob) pend[i] = 1'b1;
            end
        end
        driveInputs();

        #1;
        exp_ready = '0;
        g = -1;
        if (!m_active) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) grant_log.push_back(i);

        if (g >= 0) begin
            m_active = 1'b1;
            m_T      = cyc;
            m_id     = g;
            m_wr     = c_wr[g];
            m_addr   = c_addr[g];
            m_wdata  = c_wdata[g];
            tx_wait  = (force_w >= 0) ? force_w : $urandom_range(0, w_max);
            m_err    = (force_err >= 0) ? 1'(force_err) : ($urandom_range(0, 3) == 0);
            m_rdata  = m_wr ? '0 : ref_mem[m_addr[9:2]];
            if (stall) begin
                tx_wait = TIMEOUT_CYCLES - 1;
                m_err   = 1'b1;
                m_rdata = '0;
            end else if (m_wr) begin
                ref_mem[m_addr[9:2]] = m_wdata;
            end
            m_ptr   = (g + 1) % NUM_REQ;
            pend[g] = 1'b0;
        end
    endtask

    task automatic runUntilIdle(input int limit);
        int n = 0;
        do begin
            applyStimulus();
            n++;
        end while ((m_active || anyPend()) && n < limit);
        checkOutput("drain_bound", 32'(m_active || anyPend()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int exp_order[6] = '{0, 1, 2, 0, 1, 2};
        int n;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'(i + 1) << 16;
            s_mem[i]   = 32'(i + 1) << 16;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b1;
            c_wr[i] = 1'b0;
            c_addr[i] = '0;
            c_wdata[i] = '0;
        end
        driveInputs();
        bus.pready  = 1'b0;
        bus.prdata  = '0;
        bus.pslverr = 1'b0;

        // Reset state, with every requester asserting valid
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_psel", 32'(bus.psel), 32'd0);
        checkOutput("rst_penable", 32'(bus.penable), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("rst_paddr", 32'(bus.paddr), 32'd0);
        checkOutput("rst_pwdata", bus.pwdata, 32'd0);
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        driveInputs();
        @(negedge clk);
        rst = 1'b0;

        // Single zero-wait read from requester 0
        $display("[TB] read after reset");
        force_w = 0; force_err = 0;
        issue(0, 1'b0, 10'h008, '0);
        runUntilIdle(20);
        checkOutput("t1_rdata", last_rdata, 32'h0003_0000);
        checkOutput("t1_err", 32'(last_err), 32'd0);

        // Write then read back from requester 1
        $display("[TB] write and read-back");
        issue(1, 1'b1, 10'h020, 32'hDEAD_BEEF);
        runUntilIdle(20);
        checkOutput("t2_wr_rdata", last_rdata, 32'd0);
        issue(1, 1'b0, 10'h020, '0);
        runUntilIdle(20);
        checkOutput("t2_rd_rdata", last_rdata, 32'hDEAD_BEEF);

        // Five wait states with a slave error
        $display("[TB] wait states and slave error");
        force_w = 5; force_err = 1; acc_cycles = 0;
        issue(2, 1'b0, 10'h040, '0);
        runUntilIdle(30);
        checkOutput("t4_access_cycles", 32'(acc_cycles), 32'd6);
        checkOutput("t4_err", 32'(last_err), 32'd1);

        // Reset asserted during ACCESS
        $display("[TB] reset during access");
        force_w = 3; force_err = 0;
        issue(1, 1'b0, 10'h010, '0);
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!(m_active && cyc == m_T + 2) && n < 10);
        checkOutput("t5_reach_access", 32'(bus.penable), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_psel", 32'(bus.psel), 32'd0);
        checkOutput("t5_penable", 32'(bus.penable), 32'd0);
        checkOutput("t5_busy", 32'(bus.busy), 32'd0);
        m_active = 1'b0;
        m_ptr    = 0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        driveInputs();
        bus.pready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) applyStimulus();

        // All requesters keep valid high: strict rotation from requester 0
        $display("[TB] round-robin rotation");
        force_w = 0; force_err = -1; gen_prob = 100;
        grant_log.delete();
        n = 0;
        while (grant_log.size() < 6 && n < 100) begin
            applyStimulus();
            n++;
        end
        gen_prob = 0;
        runUntilIdle(40);
        checkOutput("t3_grant_count", 32'(grant_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) checkOutput($sformatf("t3_grant%0d", i), 32'(grant_log[i]), 32'(exp_order[i]));
        end

`ifdef OPENDDR_CFG_ARB_TIMEOUT_EN
        // Slave never answers: abort after TIMEOUT_CYCLES ACCESS cycles
        $display("[TB] access timeout");
        stall = 1'b1; acc_cycles = 0;
        issue(0, 1'b0, 10'h008, '0);
        runUntilIdle(100);
        checkOutput("t6_access_cycles", 32'(acc_cycles), 32'd64);
        checkOutput("t6_err", 32'(last_err), 32'd1);
        checkOutput("t6_rdata", last_rdata, 32'd0);
        stall = 1'b0; force_w = 0; force_err = 0;
        issue(2, 1'b0, 10'h00C, '0);
        runUntilIdle(20);
        checkOutput("t6_next_rdata", last_rdata, 32'h0004_0000);
        checkOutput("t6_next_err", 32'(last_err), 32'd0);
`endif

        // Random traffic with random wait states and errors
        $display("[TB] random traffic");
        force_w = -1; force_err = -1; w_max = 4; gen_prob = 35;
        repeat (400) applyStimulus();
        gen_prob = 0;
        runUntilIdle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
